// File: rtl/msx_fdc_glue.sv
// MSX disk-cartridge glue: register window, ROM select, motor/index timing.
// Optional disk-change latch when MSX_FDC_DSKCHG_EN is defined.
module msx_fdc_glue #(
    parameter int          NUM_DRIVES  = 2,
    parameter logic [13:0] REG_BASE    = 14'h3FF8,
    parameter logic [23:0] MOTOR_TICKS = 24'd3579545,
    parameter logic [19:0] ROT_TICKS   = 20'd715909,
    parameter logic [11:0] INDEX_W     = 12'd1432
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic [15:0]           addr,
    input  logic [7:0]            d_from_cpu,
    output logic [7:0]            d_to_cpu,
    input  logic                  sltsl_n,
    input  logic                  cs1_n,
    input  logic                  rd_n,
    input  logic                  wr_n,
    input  logic [7:0]            rom_q,
    output logic                  fdc_cs,
    input  logic [7:0]            fdc_dout,
    input  logic                  fdc_drq,
    input  logic                  fdc_intrq,
    input  logic [NUM_DRIVES-1:0] img_mounted,
    input  logic [NUM_DRIVES-1:0] img_nz,
    output logic [1:0]            drive_sel,
    output logic                  side,
    output logic                  motor_on,
    output logic                  fdc_ready,
    output logic                  index
);

    localparam logic [2:0] ND = 3'(NUM_DRIVES);

    logic                  win, rom_sel, wr_commit, wr_ctl, wr_side;
    logic [2:0]            off;
    logic                  wr_q;
    logic                  side_q, side_d;
    logic [1:0]            drive_q, drive_d;
    logic                  in_use_q, in_use_d;
    logic                  motor_q, motor_d;
    logic [23:0]           mcnt_q, mcnt_d;
    logic [19:0]           rot_q, rot_d;
    logic [NUM_DRIVES-1:0] img_q, img_d;
    logic [3:0]            img4;
    logic                  ready;
    logic [7:0]            reg6, reg_rd;
    logic                  unused_bits;

    assign off = addr[2:0];
    assign win = ~sltsl_n & (addr[15:14] == 2'b01)
               & (addr[13:3] == REG_BASE[13:3]);
    assign rom_sel = ~sltsl_n & ~cs1_n & (addr[15:14] == 2'b01) & ~win;
    assign fdc_cs = win & ~addr[2];

    // Commit only on the first clock of a write strobe.
    assign wr_commit = ~wr_n & wr_q & win;
    assign wr_ctl    = wr_commit & (off == 3'd5);
    assign wr_side   = wr_commit & (off == 3'd4);

    always_comb begin
        img4 = '0;
        img4[NUM_DRIVES-1:0] = img_q;
    end

    assign ready = motor_q & img4[drive_q] & ({1'b0, drive_q} < ND);
    assign fdc_ready = ready;
    assign index = ready & (rot_q < 20'(INDEX_W));
    assign drive_sel = drive_q;
    assign side = side_q;
    assign motor_on = motor_q;

    always_comb begin
        side_d   = side_q;
        drive_d  = drive_q;
        in_use_d = in_use_q;
        motor_d  = motor_q;
        mcnt_d   = mcnt_q;
        rot_d    = rot_q;
        img_d    = img_q;
        if (wr_side) side_d = d_from_cpu[0];
        if (wr_ctl) begin
            drive_d  = d_from_cpu[1:0];
            in_use_d = d_from_cpu[6];
            motor_d  = d_from_cpu[7];
            mcnt_d   = d_from_cpu[7] ? MOTOR_TICKS : 24'd0;
        end else if (clk_en && mcnt_q != 24'd0) begin
            mcnt_d = mcnt_q - 24'd1;
            if (mcnt_q == 24'd1) motor_d = 1'b0;
        end
        if (!ready)
            rot_d = '0;
        else if (clk_en)
            rot_d = (rot_q == ROT_TICKS - 20'd1) ? 20'd0 : rot_q + 20'd1;
        for (int d = 0; d < NUM_DRIVES; d++)
            if (img_mounted[d]) img_d[d] = img_nz[d];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q     <= 1'b0;
            side_q   <= 1'b0;
            drive_q  <= 2'd0;
            in_use_q <= 1'b0;
            motor_q  <= 1'b0;
            mcnt_q   <= '0;
            rot_q    <= '0;
            img_q    <= '0;
        end else begin
            wr_q     <= wr_n;
            side_q   <= side_d;
            drive_q  <= drive_d;
            in_use_q <= in_use_d;
            motor_q  <= motor_d;
            mcnt_q   <= mcnt_d;
            rot_q    <= rot_d;
            img_q    <= img_d;
        end
    end

`ifdef MSX_FDC_DSKCHG_EN
    logic                  rd_q, pend_q, pend_d, rd_fall;
    logic [NUM_DRIVES-1:0] chg_q, chg_d;
    logic [3:0]            chg4;

    assign rd_fall = ~rd_n & rd_q & win & (off == 3'd6);

    // Clear is deferred to strobe end so the read returns the set bit.
    always_comb begin
        pend_d = pend_q;
        chg_d  = chg_q;
        if (rd_fall) begin
            pend_d = 1'b1;
        end else if (pend_q && rd_n) begin
            pend_d = 1'b0;
            for (int d = 0; d < NUM_DRIVES; d++)
                if (drive_q == 2'(d)) chg_d[d] = 1'b0;
        end
        for (int d = 0; d < NUM_DRIVES; d++)
            if (img_mounted[d]) chg_d[d] = 1'b1;
        chg4 = '0;
        chg4[NUM_DRIVES-1:0] = chg_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q   <= 1'b0;
            pend_q <= 1'b0;
            chg_q  <= '0;
        end else begin
            rd_q   <= rd_n;
            pend_q <= pend_d;
            chg_q  <= chg_d;
        end
    end

    assign reg6 = {4'hF, chg4};
    assign unused_bits = ^{d_from_cpu[5:2]};
`else
    assign reg6 = 8'hFF;
    assign unused_bits = ^{d_from_cpu[5:2], rd_n};
`endif

    always_comb begin
        case (off)
            3'd4:    reg_rd = {7'h7F, ~side_q};
            3'd5:    reg_rd = {motor_q, in_use_q, 4'hF, drive_q};
            3'd6:    reg_rd = reg6;
            3'd7:    reg_rd = {~fdc_drq, ~fdc_intrq, 6'h3F};
            default: reg_rd = fdc_dout;
        endcase
        if (rom_sel)
            d_to_cpu = rom_q;
        else if (win && !rd_n)
            d_to_cpu = reg_rd;
        else
            d_to_cpu = 8'hFF;
    end

endmodule

// File: tb/tb_msx_fdc_glue.sv
// Directed bench for msx_fdc_glue with short motor/rotation timers.
// Offset-6 checks follow MSX_FDC_DSKCHG_EN.
module tb_msx_fdc_glue;

    logic       clk = 1'b0;
    logic       reset, clk_en;
    logic [15:0] addr;
    logic [7:0] d_from_cpu, d_to_cpu, rom_q, fdc_dout;
    logic       sltsl_n, cs1_n, rd_n, wr_n;
    logic       fdc_cs, fdc_drq, fdc_intrq;
    logic [1:0] img_mounted, img_nz, drive_sel;
    logic       side, motor_on, fdc_ready, index;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rv;
    logic       rcs;

    msx_fdc_glue #(
        .NUM_DRIVES (2),
        .REG_BASE   (14'h3FF8),
        .MOTOR_TICKS(24'd16),
        .ROT_TICKS  (20'd100),
        .INDEX_W    (12'd4)
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .addr(addr),
        .d_from_cpu(d_from_cpu), .d_to_cpu(d_to_cpu),
        .sltsl_n(sltsl_n), .cs1_n(cs1_n), .rd_n(rd_n), .wr_n(wr_n),
        .rom_q(rom_q), .fdc_cs(fdc_cs), .fdc_dout(fdc_dout),
        .fdc_drq(fdc_drq), .fdc_intrq(fdc_intrq),
        .img_mounted(img_mounted), .img_nz(img_nz),
        .drive_sel(drive_sel), .side(side), .motor_on(motor_on),
        .fdc_ready(fdc_ready), .index(index)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr = a;
        d_from_cpu = d;
        wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic rd(input logic [15:0] a);
        addr = a;
        rd_n = 1'b0;
        @(negedge clk);
        rv = d_to_cpu;
        rcs = fdc_cs;
        rd_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic mount(input logic [1:0] m, input logic [1:0] nz);
        img_mounted = m;
        img_nz = nz;
        @(negedge clk);
        img_mounted = 2'b00;
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b0; addr = 16'h0000; d_from_cpu = 8'h00;
        sltsl_n = 1'b1; cs1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        rom_q = 8'hC3; fdc_dout = 8'h5A; fdc_drq = 1'b0; fdc_intrq = 1'b0;
        img_mounted = 2'b00; img_nz = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk1("rst_motor", motor_on, 1'b0);
        chk8("rst_drive", {6'd0, drive_sel}, 8'h00);
        chk1("rst_side", side, 1'b0);
        chk1("rst_index", index, 1'b0);
        chk1("rst_ready", fdc_ready, 1'b0);
        chk8("rst_dout", d_to_cpu, 8'hFF);

        sltsl_n = 1'b0; cs1_n = 1'b0;

        wr(16'h7FFD, 8'h81);
        chk1("t1_motor", motor_on, 1'b1);
        chk8("t1_drive", {6'd0, drive_sel}, 8'h01);
        rd(16'h7FFD);
        chk8("t1_ctl_rd", rv, 8'hBD);

        clk_en = 1'b1;
        wr(16'h7FFD, 8'h81);
        repeat (14) @(negedge clk);
        chk1("t2_tick15_on", motor_on, 1'b1);
        @(negedge clk);
        chk1("t2_tick16_off", motor_on, 1'b0);

        wr(16'h7FFD, 8'h81);
        repeat (14) @(negedge clk);
        wr(16'h7FFD, 8'h81);
        chk1("t2_reload_on", motor_on, 1'b1);
        repeat (14) @(negedge clk);
        chk1("t2_ext_tick15_on", motor_on, 1'b1);
        @(negedge clk);
        chk1("t2_ext_tick16_off", motor_on, 1'b0);

        clk_en = 1'b0;
        mount(2'b10, 2'b10);
        wr(16'h7FFD, 8'h81);
        chk1("t3_ready", fdc_ready, 1'b1);
        chk1("t3_index_start", index, 1'b1);

        addr = 16'h7FFD;
        d_from_cpu = 8'h81;
        for (int i = 0; i < 200; i++) begin
            chk1("t4_index", index, (i % 100) < 4);
            clk_en = 1'b1;
            wr_n = (i % 8 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        wr_n = 1'b1;
        chk1("t4_index_pre_off", index, 1'b1);
        d_from_cpu = 8'h01;
        wr_n = 1'b0;
        @(negedge clk);
        chk1("t4_off_motor", motor_on, 1'b0);
        chk1("t4_off_index", index, 1'b0);
        wr_n = 1'b1;
        @(negedge clk);

        clk_en = 1'b0;
        wr(16'h7FFD, 8'h82);
        chk1("t3_d2_motor", motor_on, 1'b1);
        chk8("t3_d2_drive", {6'd0, drive_sel}, 8'h02);
        chk1("t3_d2_ready", fdc_ready, 1'b0);
        chk1("t3_d2_index", index, 1'b0);
        rd(16'h7FFD);
        chk8("t3_d2_ctl_rd", rv, 8'hBE);

        rd(16'h7FF9);
        chk8("t5_fdc_rd", rv, 8'h5A);
        chk1("t5_fdc_cs", rcs, 1'b1);
        rd(16'h5000);
        chk8("t5_rom_rd", rv, 8'hC3);
        chk1("t5_rom_cs", rcs, 1'b0);
        fdc_drq = 1'b1;
        rd(16'h7FFF);
        chk8("t5_status", rv, 8'h7F);
        rd(16'h7FFC);
        chk8("t5_side0", rv, 8'hFF);
        wr(16'h7FFC, 8'h01);
        chk1("t5_side", side, 1'b1);
        rd(16'h7FFC);
        chk8("t5_side1", rv, 8'hFE);
        sltsl_n = 1'b1;
        rd(16'h7FFD);
        chk8("t5_unsel", rv, 8'hFF);
        sltsl_n = 1'b0;

        wr(16'h7FFD, 8'h00);
`ifdef MSX_FDC_DSKCHG_EN
        rd(16'h7FFE);
        chk8("t6_pre", rv, 8'hF2);
        mount(2'b01, 2'b01);
        rd(16'h7FFE);
        chk8("t6_first", rv, 8'hF3);
        rd(16'h7FFE);
        chk8("t6_second", rv, 8'hF2);
        mount(2'b01, 2'b01);
        addr = 16'h7FFE;
        rd_n = 1'b0;
        @(negedge clk);
        chk8("t6_coll_rd", d_to_cpu, 8'hF3);
        rd_n = 1'b1;
        img_mounted = 2'b01;
        @(negedge clk);
        img_mounted = 2'b00;
        @(negedge clk);
        rd(16'h7FFE);
        chk8("t6_set_wins", rv, 8'hF3);
        rd(16'h7FFE);
        chk8("t6_after", rv, 8'hF2);
`else
        rd(16'h7FFE);
        chk8("t6_off6", rv, 8'hFF);
`endif

        addr = 16'h7FFD;
        d_from_cpu = 8'h81;
        wr_n = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst2_motor", motor_on, 1'b0);
        chk8("rst2_drive", {6'd0, drive_sel}, 8'h00);
        chk1("rst2_side", side, 1'b0);
        wr_n = 1'b1;
        @(negedge clk);
        wr(16'h7FFD, 8'h81);
        chk1("rst2_motor_on", motor_on, 1'b1);
        chk1("rst2_img_clr", fdc_ready, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
